// File: rtl/vec_fwd_hazard_unit.sv
// rtl/vec_fwd_hazard_unit.sv - Forwarding and load-use hazard unit for the ID/EX/MEM/WB vector pipeline
module vec_fwd_hazard_unit #(
  parameter int DATA_W   = 128,
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr_i,
  input  logic [NUM_SRC-1:0]          id_src_used_i,
  input  logic [REG_AW-1:0]           id_dst_addr_i,
  input  logic                        id_dst_we_i,
  input  logic                        id_is_load_i,
  input  logic                        flush_i,
  input  logic [NUM_SRC*DATA_W-1:0]   ex_rf_data_i,
  input  logic [DATA_W-1:0]           mem_result_i,
  input  logic [DATA_W-1:0]           wb_result_i,
  output logic [NUM_SRC*DATA_W-1:0]   ex_opnd_o,
  output logic [NUM_SRC*2-1:0]        fwd_sel_o,
  output logic                        stall_o,
  output logic [CNT_W-1:0]            stall_count_o
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam bit         ZR      = (ZERO_REG != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // EX stage tag: full source information is needed here for forwarding
  logic                      ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0]         ex_dst_q, ex_dst_d;
  logic                      ex_we_q, ex_we_d;
  logic                      ex_is_load_q, ex_is_load_d;
  logic [NUM_SRC*REG_AW-1:0] ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0]        ex_used_q, ex_used_d;

  // MEM stage tag
  logic                      mem_valid_q, mem_valid_d;
  logic [REG_AW-1:0]         mem_dst_q, mem_dst_d;
  logic                      mem_we_q, mem_we_d;
  logic                      mem_is_load_q, mem_is_load_d;

  // WB stage tag; whether it was a load no longer matters once data is in WB
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0]         wb_dst_q, wb_dst_d;
  logic                      wb_we_q, wb_we_d;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_SRC-1:0]        id_src_hit;
  logic                      ex_load_hazard;

  // A load sitting in EX whose destination is not the hard-wired zero register
  assign ex_load_hazard = ex_valid_q && ex_is_load_q && ex_we_q &&
                          !(ZR && (ex_dst_q == '0));

  genvar g;
  for (g = 0; g < NUM_SRC; g++) begin : g_src
    logic [REG_AW-1:0] src;
    logic              rd;
    logic              mem_hit;
    logic              wb_hit;

    // ID-side dependency on the EX destination for the load-use check
    assign id_src_hit[g] = id_src_used_i[g] &&
                           (id_src_addr_i[g*REG_AW +: REG_AW] == ex_dst_q);

    // EX-side operand selection; MEM is newer than WB so it wins
    assign src     = ex_src_q[g*REG_AW +: REG_AW];
    assign rd      = ex_valid_q && ex_used_q[g] && !(ZR && (src == '0));
    assign mem_hit = rd && mem_valid_q && mem_we_q && !mem_is_load_q &&
                     (mem_dst_q == src);
    assign wb_hit  = rd && wb_valid_q && wb_we_q && (wb_dst_q == src);

    assign fwd_sel_o[g*2 +: 2] = mem_hit ? SEL_MEM :
                                 wb_hit  ? SEL_WB  : SEL_RF;
    assign ex_opnd_o[g*DATA_W +: DATA_W] =
        mem_hit ? mem_result_i :
        wb_hit  ? wb_result_i  : ex_rf_data_i[g*DATA_W +: DATA_W];
  end

  // Load-use stall; a flush squashes ID anyway so it overrides the stall
  always_comb begin
    stall_o = 1'b0;
    if (!flush_i && id_valid_i && ex_load_hazard && (|id_src_hit)) begin
      stall_o = 1'b1;
    end
  end

  // Next-state of the tag pipeline and the saturating stall counter
  always_comb begin
    ex_valid_d    = id_valid_i && !flush_i && !stall_o;
    ex_dst_d      = id_dst_addr_i;
    ex_we_d       = id_dst_we_i;
    ex_is_load_d  = id_is_load_i;
    ex_src_d      = id_src_addr_i;
    ex_used_d     = id_src_used_i;
    mem_valid_d   = ex_valid_q;
    mem_dst_d     = ex_dst_q;
    mem_we_d      = ex_we_q;
    mem_is_load_d = ex_is_load_q;
    wb_valid_d    = mem_valid_q;
    wb_dst_d      = mem_dst_q;
    wb_we_d       = mem_we_q;
    cnt_d         = cnt_q;
    if (stall_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Valid bits and counter carry the synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Tag payload fields are qualified by the valid bits and need no reset
  always_ff @(posedge clk_i) begin
    ex_dst_q      <= ex_dst_d;
    ex_we_q       <= ex_we_d;
    ex_is_load_q  <= ex_is_load_d;
    ex_src_q      <= ex_src_d;
    ex_used_q     <= ex_used_d;
    mem_dst_q     <= mem_dst_d;
    mem_we_q      <= mem_we_d;
    mem_is_load_q <= mem_is_load_d;
    wb_dst_q      <= wb_dst_d;
    wb_we_q       <= wb_we_d;
  end

  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_vec_fwd_hazard_unit.sv
// tb/tb_vec_fwd_hazard_unit.sv - Self-checking bench for vec_fwd_hazard_unit
module tb_vec_fwd_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, id_valid, flush, id_dst_we, id_is_load;
  logic [7:0]   id_src_addr;
  logic [1:0]   id_src_used;
  logic [3:0]   id_dst_addr;
  logic [255:0] ex_rf_data;
  logic [127:0] mem_result, wb_result;

  logic [255:0] o0_opnd, o1_opnd;
  logic [3:0]   o0_sel, o1_sel;
  logic         o0_stall, o1_stall;
  logic [15:0]  o0_cnt;
  logic [3:0]   o1_cnt;

  vec_fwd_hazard_unit #(.DATA_W(128), .REG_AW(4), .NUM_SRC(2), .ZERO_REG(0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_src_addr_i(id_src_addr),
    .id_src_used_i(id_src_used), .id_dst_addr_i(id_dst_addr), .id_dst_we_i(id_dst_we),
    .id_is_load_i(id_is_load), .flush_i(flush), .ex_rf_data_i(ex_rf_data),
    .mem_result_i(mem_result), .wb_result_i(wb_result), .ex_opnd_o(o0_opnd),
    .fwd_sel_o(o0_sel), .stall_o(o0_stall), .stall_count_o(o0_cnt));

  vec_fwd_hazard_unit #(.DATA_W(128), .REG_AW(4), .NUM_SRC(2), .ZERO_REG(1), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_src_addr_i(id_src_addr),
    .id_src_used_i(id_src_used), .id_dst_addr_i(id_dst_addr), .id_dst_we_i(id_dst_we),
    .id_is_load_i(id_is_load), .flush_i(flush), .ex_rf_data_i(ex_rf_data),
    .mem_result_i(mem_result), .wb_result_i(wb_result), .ex_opnd_o(o1_opnd),
    .fwd_sel_o(o1_sel), .stall_o(o1_stall), .stall_count_o(o1_cnt));

  typedef struct packed {
    logic       v;
    logic [3:0] dst;
    logic       we;
    logic       ld;
    logic [7:0] src;
    logic [1:0] used;
  } ins_t;

  // Instruction history by age: [0] in EX, [1] in MEM, [2] in WB
  ins_t age0 [3];
  ins_t age1 [3];
  int unsigned cnt0, cnt1;
  int n_cmp, n_bad;

  logic         e0_st, e1_st;
  logic [3:0]   e0_sel, e1_sel;
  logic [255:0] e0_op, e1_op;

  function automatic void predict(input ins_t ex, input ins_t mem, input ins_t wb, input bit zr,
                                  output logic st, output logic [3:0] sel, output logic [255:0] op);
    st = 1'b0;
    if (!flush && id_valid && ex.v && ex.ld && ex.we && !(zr && ex.dst == 4'd0))
      for (int i = 0; i < 2; i++)
        if (id_src_used[i] && id_src_addr[i*4 +: 4] == ex.dst) st = 1'b1;
    for (int i = 0; i < 2; i++) begin
      logic [3:0] s;
      logic rd;
      s  = ex.src[i*4 +: 4];
      rd = ex.v && ex.used[i] && !(zr && s == 4'd0);
      if (rd && mem.v && mem.we && !mem.ld && mem.dst == s) begin
        sel[i*2 +: 2] = 2'b01; op[i*128 +: 128] = mem_result;
      end else if (rd && wb.v && wb.we && wb.dst == s) begin
        sel[i*2 +: 2] = 2'b10; op[i*128 +: 128] = wb_result;
      end else begin
        sel[i*2 +: 2] = 2'b00; op[i*128 +: 128] = ex_rf_data[i*128 +: 128];
      end
    end
  endfunction

  task automatic eval_all();
    predict(age0[0], age0[1], age0[2], 1'b0, e0_st, e0_sel, e0_op);
    predict(age1[0], age1[1], age1[2], 1'b1, e1_st, e1_sel, e1_op);
  endtask

  task automatic tick();
    ins_t n;
    eval_all();
    n = '{v: id_valid, dst: id_dst_addr, we: id_dst_we, ld: id_is_load,
          src: id_src_addr, used: id_src_used};
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin age0[k].v = 1'b0; age1[k].v = 1'b0; end
      cnt0 = 0; cnt1 = 0;
    end else begin
      age0[2] = age0[1]; age0[1] = age0[0]; age0[0] = n;
      age0[0].v = id_valid && !flush && !e0_st;
      age1[2] = age1[1]; age1[1] = age1[0]; age1[0] = n;
      age1[0].v = id_valid && !flush && !e1_st;
      if (e0_st && cnt0 < 65535) cnt0++;
      if (e1_st && cnt1 < 15) cnt1++;
    end
    #1;
  endtask

  task automatic issue(input bit v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] u, input logic [3:0] d, input bit we, input bit ld);
    id_valid = v; id_src_addr = {s1, s0}; id_src_used = u;
    id_dst_addr = d; id_dst_we = we; id_is_load = ld;
  endtask

  task automatic rand_data();
    ex_rf_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    mem_result = {$urandom, $urandom, $urandom, $urandom};
    wb_result  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; issue(0, 0, 0, 0, 0, 0, 0); rand_data();
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (o0_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", o0_stall); end
    n_cmp++; if (o0_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", o0_cnt); end
    n_cmp++; if (o1_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt1 got %0d want 0", o1_cnt); end
    n_cmp++; if (o0_sel !== 4'b0000) begin n_bad++; $display("FAIL reset_sel got %b want 0000", o0_sel); end
    n_cmp++; if (o0_opnd !== ex_rf_data) begin n_bad++; $display("FAIL reset_opnd got %h want %h", o0_opnd, ex_rf_data); end
    tick();
  endtask

  task automatic test_no_hazard();
    issue(1, 0, 0, 2'b00, 0, 1, 0); tick();
    issue(1, 0, 0, 2'b00, 8, 1, 0); tick();
    issue(1, 5, 6, 2'b11, 9, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0, 0); rand_data();
    ex_rf_data = {128'h64, 128'h10};
    #1;
    n_cmp++; if (o0_opnd !== {128'h64, 128'h10}) begin n_bad++; $display("FAIL nohaz_opnd got %h want 64/10", o0_opnd); end
    n_cmp++; if (o0_sel !== 4'b0000) begin n_bad++; $display("FAIL nohaz_sel got %b want 0000", o0_sel); end
    n_cmp++; if (o0_stall !== 1'b0) begin n_bad++; $display("FAIL nohaz_stall got %b want 0", o0_stall); end
    tick();
  endtask

  task automatic test_mem_wb_fwd();
    issue(1, 0, 0, 2'b00, 6, 1, 0); tick();
    issue(1, 0, 0, 2'b00, 5, 1, 0); tick();
    issue(1, 5, 6, 2'b11, 10, 1, 0); tick();
    issue(0, 0, 0, 0, 0, 0, 0); rand_data();
    mem_result = 128'h15; wb_result = 128'h16;
    #1;
    n_cmp++; if (o0_opnd !== {128'h16, 128'h15}) begin n_bad++; $display("FAIL memwb_opnd got %h want 16/15", o0_opnd); end
    n_cmp++; if (o0_sel !== 4'b1001) begin n_bad++; $display("FAIL memwb_sel got %b want 1001", o0_sel); end
    tick();
    issue(1, 0, 0, 2'b00, 7, 1, 0); tick();
    issue(1, 0, 0, 2'b00, 7, 1, 0); tick();
    issue(1, 7, 7, 2'b01, 11, 1, 0); tick();
    issue(0, 0, 0, 0, 0, 0, 0); rand_data();
    #1;
    n_cmp++; if (o0_sel !== 4'b0001) begin n_bad++; $display("FAIL same_reg_sel got %b want 0001", o0_sel); end
    n_cmp++; if (o0_opnd !== {ex_rf_data[255:128], mem_result}) begin n_bad++; $display("FAIL same_reg_opnd got %h want %h", o0_opnd, {ex_rf_data[255:128], mem_result}); end
    tick();
  endtask

  task automatic test_load_use();
    int unsigned base;
    base = cnt0;
    issue(1, 0, 0, 2'b00, 3, 1, 1); tick();
    issue(1, 3, 1, 2'b01, 4, 1, 0); rand_data();
    #1;
    n_cmp++; if (o0_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b want 1", o0_stall); end
    n_cmp++; if (o1_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall1 got %b want 1", o1_stall); end
    tick();
    #1;
    n_cmp++; if (o0_stall !== 1'b0) begin n_bad++; $display("FAIL lu_one_cycle got %b want 0", o0_stall); end
    n_cmp++; if (o0_sel !== 4'b0000) begin n_bad++; $display("FAIL lu_bubble_sel got %b want 0000", o0_sel); end
    n_cmp++; if (o0_cnt !== 16'(base + 1)) begin n_bad++; $display("FAIL lu_cnt got %0d want %0d", o0_cnt, base + 1); end
    tick();
    issue(0, 0, 0, 0, 0, 0, 0); wb_result = 128'hABCD;
    #1;
    n_cmp++; if (o0_sel[1:0] !== 2'b10) begin n_bad++; $display("FAIL lu_fwd_sel got %b want 10", o0_sel[1:0]); end
    n_cmp++; if (o0_opnd[127:0] !== 128'hABCD) begin n_bad++; $display("FAIL lu_fwd_opnd got %h want abcd", o0_opnd[127:0]); end
    tick();
  endtask

  task automatic test_flush();
    int unsigned base;
    base = cnt0;
    issue(1, 0, 0, 2'b00, 3, 1, 1); tick();
    issue(1, 3, 0, 2'b01, 4, 1, 0); flush = 1'b1; rand_data();
    #1;
    n_cmp++; if (o0_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", o0_stall); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (o0_stall !== 1'b0) begin n_bad++; $display("FAIL flush_ex_invalid_stall got %b want 0", o0_stall); end
    n_cmp++; if (o0_sel !== 4'b0000) begin n_bad++; $display("FAIL flush_ex_invalid_sel got %b want 0000", o0_sel); end
    n_cmp++; if (o0_cnt !== 16'(base)) begin n_bad++; $display("FAIL flush_cnt got %0d want %0d", o0_cnt, base); end
    tick();
    issue(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (o0_sel[1:0] !== 2'b10) begin n_bad++; $display("FAIL flush_wb_fwd got %b want 10", o0_sel[1:0]); end
    tick();
  endtask

  task automatic test_zero_reg();
    issue(1, 0, 0, 2'b00, 0, 1, 0); tick();
    issue(1, 0, 0, 2'b01, 9, 0, 0); tick();
    issue(0, 0, 0, 0, 0, 0, 0); rand_data();
    #1;
    n_cmp++; if (o1_sel !== 4'b0000) begin n_bad++; $display("FAIL zr_sel got %b want 0000", o1_sel); end
    n_cmp++; if (o0_sel[1:0] !== 2'b01) begin n_bad++; $display("FAIL nozr_sel got %b want 01", o0_sel[1:0]); end
    tick();
    issue(1, 0, 0, 2'b00, 0, 1, 1); tick();
    issue(1, 0, 0, 2'b01, 9, 0, 0);
    #1;
    n_cmp++; if (o1_stall !== 1'b0) begin n_bad++; $display("FAIL zr_load_stall got %b want 0", o1_stall); end
    n_cmp++; if (o0_stall !== 1'b1) begin n_bad++; $display("FAIL nozr_load_stall got %b want 1", o0_stall); end
    tick(); tick();
    issue(0, 0, 0, 0, 0, 0, 0); tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 9) == 0);
      issue($urandom_range(0, 9) < 8, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 4);
      rand_data();
      #1;
      eval_all();
      n_cmp++;
      if ({o0_stall, o0_sel, o0_cnt, o0_opnd} !== {e0_st, e0_sel, cnt0[15:0], e0_op}) begin
        n_bad++;
        $display("FAIL rand0 cyc %0d got st=%b sel=%b cnt=%0d op=%h want st=%b sel=%b cnt=%0d op=%h",
                 c, o0_stall, o0_sel, o0_cnt, o0_opnd, e0_st, e0_sel, cnt0, e0_op);
      end
      n_cmp++;
      if ({o1_stall, o1_sel, o1_cnt, o1_opnd} !== {e1_st, e1_sel, cnt1[3:0], e1_op}) begin
        n_bad++;
        $display("FAIL rand1 cyc %0d got st=%b sel=%b cnt=%0d op=%h want st=%b sel=%b cnt=%0d op=%h",
                 c, o1_stall, o1_sel, o1_cnt, o1_opnd, e1_st, e1_sel, cnt1, e1_op);
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1; issue(0, 0, 0, 0, 0, 0, 0); tick(); rst = 1'b0;
    issue(1, 0, 0, 2'b00, 2, 1, 1); tick();
    issue(1, 2, 0, 2'b01, 5, 1, 0);
    #1;
    n_cmp++; if (o1_stall !== 1'b1) begin n_bad++; $display("FAIL midstall_pre got %b want 1", o1_stall); end
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    n_cmp++; if (o0_stall !== 1'b0) begin n_bad++; $display("FAIL midstall_rst_stall got %b want 0", o0_stall); end
    n_cmp++; if (o0_cnt !== 16'd0) begin n_bad++; $display("FAIL midstall_rst_cnt got %0d want 0", o0_cnt); end
    tick();
    for (int k = 0; k < 20; k++) begin
      issue(1, 0, 0, 2'b00, 2, 1, 1); tick();
      issue(1, 2, 0, 2'b01, 5, 1, 0); tick(); tick();
    end
    issue(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (o1_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_cnt4 got %0d want 15", o1_cnt); end
    n_cmp++; if (o0_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_cnt16 got %0d want 20", o0_cnt); end
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    n_cmp++; if (o1_cnt !== 4'd0) begin n_bad++; $display("FAIL sat_rst_cnt got %0d want 0", o1_cnt); end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 3; k++) begin age0[k] = '0; age1[k] = '0; end
    rst = 1'b1; flush = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0); rand_data();
    #1;
    test_reset();
    test_no_hazard();
    test_mem_wb_fwd();
    test_load_use();
    test_flush();
    test_zero_reg();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
